// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity-type
// encoding and the oversample decision point.
// UART_RX_MAJORITY_VOTE_EN moves the decision point one count later, so the
// third vote sample has arrived when the decision is taken.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Oversample count at which a bit value is decided.
  function automatic int sample_point(input int prescale);
`ifdef UART_RX_MAJORITY_VOTE_EN
    return prescale / 2 + 1;
`else
    return prescale / 2;
`endif
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Oversample counter and bit-decision logic for the UART receiver.
// With UART_RX_MAJORITY_VOTE_EN defined, a bit is the 2-of-3 vote of the
// samples at PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1; otherwise it is the
// single sample at PRESCALE/2.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic start,        // start edge seen in IDLE: this cycle is cnt 0
  input  logic active,       // a frame is in progress
  input  logic clear,        // frame ends this cycle, park the counter
  output logic sample_valid,
  output logic sampled_bit,
  output logic bit_end
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(sample_point(PRESCALE));
  localparam logic [CW-1:0] LAST_CNT   = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Per-bit oversample counter; the start-edge cycle counts as cnt 0.
  always_ff @(posedge clk) begin
    if (reset)                                  cnt <= '0;
    else if (start)                             cnt <= CW'(1);
    else if (!active || clear || cnt == LAST_CNT) cnt <= '0;
    else                                        cnt <= cnt + 1'b1;
  end

  assign sample_valid = active && (cnt == SAMPLE_CNT);
  assign bit_end      = active && (cnt == LAST_CNT);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic line_d1, line_d2;

  // Two-deep line history so the vote sees cnt-2, cnt-1 and cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_d1 <= 1'b1;
      line_d2 <= 1'b1;
    end else begin
      line_d1 <= line;
      line_d2 <= line_d1;
    end
  end

  assign sampled_bit = (line_d2 & line_d1) | (line_d2 & line) | (line_d1 & line);
`else
  assign sampled_bit = line;
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start/data/parity/stop framing on an oversampled line,
// LSB-first data, one-cycle valid and error pulses.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (3-sample majority vote,
// all pulses one cycle later).
module uart_receiver
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_data_in,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [IW-1:0]         bit_idx;
  logic                  par_en_q, par_type_q, par_err_q;
  logic                  exp_par;
  logic                  start_det, to_idle;
  logic                  sample_valid, sampled_bit, bit_end;

  assign start_det = (state == IDLE) && !serial_data_in;
  // Frame ends at a glitching start sample or at the stop sample.
  assign to_idle   = sample_valid &&
                     (((state == START) && sampled_bit) || (state == STOP));

  uart_rx_bit_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk          (clk),
    .reset        (reset),
    .line         (serial_data_in),
    .start        (start_det),
    .active       (state != IDLE),
    .clear        (to_idle),
    .sample_valid (sample_valid),
    .sampled_bit  (sampled_bit),
    .bit_end      (bit_end)
  );

  // Parity bit the transmitter should have sent for the received word.
  always_comb begin
    exp_par = 1'b0;
    case (par_type_q)
      PARITY_EVEN: exp_par = ^shift;
      PARITY_ODD:  exp_par = ~^shift;
    endcase
  end

  // Frame FSM with registered word, pulses and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shift         <= '0;
      bit_idx       <= '0;
      par_en_q      <= 1'b0;
      par_type_q    <= 1'b0;
      par_err_q     <= 1'b0;
      parallel_data <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      stop_error    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start_det;
          if (start_det) begin
            state      <= START;
            par_en_q   <= parity_enable;
            par_type_q <= parity_type;
            par_err_q  <= 1'b0;
            bit_idx    <= '0;
          end
        end
        START: begin
          if (sample_valid && sampled_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (sample_valid) shift[bit_idx] <= sampled_bit;
          if (bit_end) begin
            if (bit_idx == LAST_IDX) state <= par_en_q ? PARITY : STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: begin
          if (sample_valid) par_err_q <= (sampled_bit != exp_par);
          if (bit_end)      state     <= STOP;
        end
        STOP: begin
          // Leave right at the sample point so a back-to-back start resyncs;
          // busy stays high through the pulse cycle.
          if (sample_valid) begin
            state        <= IDLE;
            stop_error   <= !sampled_bit;
            parity_error <= par_err_q;
            if (sampled_bit && !par_err_q) begin
              data_valid    <= 1'b1;
              parallel_data <= shift;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a cycle-indexed line waveform is
// built up front, a frame-level model derives every expected output from it,
// and one compare process checks the DUT each cycle.
module tb_uart_receiver;

  localparam int P  = 8;
  localparam int DW = 8;
  localparam int N  = 8192;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, serial_data_in, parity_enable, parity_type;
  logic [DW-1:0] parallel_data;
  logic          data_valid, parity_error, stop_error, busy;

  uart_receiver #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (serial_data_in),
    .parity_enable  (parity_enable),
    .parity_type    (parity_type),
    .parallel_data  (parallel_data),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .stop_error     (stop_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // stimulus per cycle
  logic line_a[N], rst_a[N], pe_a[N], pt_a[N];
  // expectations per cycle
  logic          ex_dv[N], ex_pe[N], ex_se[N], ex_busy[N];
  logic [DW-1:0] ex_pd[N];
  logic          evt_v[N];
  logic [DW-1:0] evt_d[N];

  int len, checks, failures, cyc;
  bit running;

  task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, n, got, exp);
    end
  endtask

  // ---------------- stimulus builders ----------------
  task automatic put(input logic l, input int n);
    for (int k = 0; k < n; k++) begin
      if (len < N) begin
        line_a[len] = l;
        rst_a[len]  = 1'b0;
        pe_a[len]   = 1'($urandom);   // mid-frame noise on the config inputs
        pt_a[len]   = 1'($urandom);
        len++;
      end
    end
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                       input logic pbit, input logic stop, input int stop_len, output int t0);
    t0 = len;
    put(1'b0, P);
    pe_a[t0] = pe;
    pt_a[t0] = pt;
    for (int i = 0; i < DW; i++) put(d[i], P);
    if (pe) put(pbit, P);
    put(stop, stop_len);
  endtask

  function automatic logic good_par(input logic [DW-1:0] d, input logic pt);
    return (^d) ^ pt;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic bitval(input int tc);
    if (MAJ != 0)
      return (line_a[tc-2] & line_a[tc-1]) | (line_a[tc-2] & line_a[tc]) | (line_a[tc-1] & line_a[tc]);
    return line_a[tc];
  endfunction

  task automatic run_model();
    int t, t0, tg, ts, r, nb;
    logic glitch, perr, stop, pen;
    logic [DW-1:0] w, cur;
    for (int n = 0; n < N; n++) begin
      ex_dv[n] = 0; ex_pe[n] = 0; ex_se[n] = 0; ex_busy[n] = 0;
      evt_v[n] = 0; evt_d[n] = '0; ex_pd[n] = '0;
    end
    t = 0;
    while (t < len) begin
      if (rst_a[t]) begin
        if (t + 1 < N) begin evt_v[t+1] = 1; evt_d[t+1] = '0; end
        t++;
        continue;
      end
      if (line_a[t]) begin t++; continue; end
      t0 = t;
      tg = t0 + P/2 + MAJ;
      if (tg + 1 >= len) break;
      glitch = bitval(tg);
      ts = tg; perr = 0; stop = 0; w = '0;
      if (!glitch) begin
        pen = pe_a[t0];
        nb  = 1 + DW + (pen ? 1 : 0);
        ts  = t0 + P*nb + P/2 + MAJ;
        if (ts + 1 >= len) break;
        for (int i = 0; i < DW; i++) w[i] = bitval(t0 + P*(1+i) + P/2 + MAJ);
        if (pen) perr = bitval(t0 + P*(1+DW) + P/2 + MAJ) != good_par(w, pt_a[t0]);
        stop = bitval(ts);
      end
      r = -1;
      for (int k = t0 + 1; k <= ts; k++) if (r < 0 && rst_a[k]) r = k;
      if (r >= 0) begin
        for (int k = t0 + 1; k <= r; k++) ex_busy[k] = 1;
        t = r;
        continue;
      end
      if (glitch) begin
        for (int k = t0 + 1; k <= tg; k++) ex_busy[k] = 1;
        t = tg + 1;
      end else begin
        for (int k = t0 + 1; k <= ts + 1; k++) ex_busy[k] = 1;
        ex_dv[ts+1] = stop && !perr;
        ex_se[ts+1] = !stop;
        ex_pe[ts+1] = perr;
        if (stop && !perr) begin evt_v[ts+1] = 1; evt_d[ts+1] = w; end
        t = ts + 1;
      end
    end
    cur = '0;
    for (int n = 0; n < N; n++) begin
      if (evt_v[n]) cur = evt_d[n];
      ex_pd[n] = cur;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (running && cyc >= 1) begin
      chk("data_valid",    cyc, 32'(data_valid),    32'(ex_dv[cyc]));
      chk("parity_error",  cyc, 32'(parity_error),  32'(ex_pe[cyc]));
      chk("stop_error",    cyc, 32'(stop_error),    32'(ex_se[cyc]));
      chk("busy",          cyc, 32'(busy),          32'(ex_busy[cyc]));
      chk("parallel_data", cyc, 32'(parallel_data), 32'(ex_pd[cyc]));
    end
  end

  // ---------------- main ----------------
  initial begin
    int t1, t2, t3, t4, t5, t6, t7, t8, t9, tr, sel, lat0, latp;
    logic [DW-1:0] d;
    logic pe, pt;
    checks = 0; failures = 0; len = 0; cyc = 0; running = 0;
    lat0 = 77 + MAJ;
    latp = 85 + MAJ;

    // reset, then directed frames
    put(1'b1, 10);
    rst_a[0] = 1; rst_a[1] = 1; rst_a[2] = 1;
    frame(8'hA5, 0, 0, 0, 1, P, t1);          put(1'b1, 5);
    frame(8'h37, 1, 0, 1, 1, P, t2);          put(1'b1, 5);
    frame(8'h37, 1, 0, 0, 1, P, t3);          put(1'b1, 5);
    frame(8'h5A, 0, 0, 0, 0, P, t4);          put(1'b1, 12);
    t5 = len; put(1'b0, 3);                    put(1'b1, 12);
    frame(8'h01, 0, 0, 0, 1, P, t6);
    frame(8'hFF, 0, 0, 0, 1, P, t7);          put(1'b1, 5);
    frame(8'h96, 0, 0, 0, 1, P, t8);
    rst_a[t8+30] = 1;
    for (int k = t8 + 31; k < len; k++) line_a[k] = 1'b1;
    put(1'b1, 10);
    frame(8'h3C, 0, 0, 0, 1, P, t9);          put(1'b1, 5);

    // randomized traffic
    for (int it = 0; it < 45; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        put(1'b0, $urandom_range(1, P/2 - 1));
        put(1'b1, 5);
      end else if (sel == 1) begin
        put(1'b1, $urandom_range(1, 20));
      end else begin
        d  = 8'($urandom);
        pe = 1'($urandom);
        pt = 1'($urandom);
        frame(d, pe, pt, good_par(d, pt) ^ ($urandom_range(0, 4) == 0),
              $urandom_range(0, 9) != 0,
              ($urandom_range(0, 1) != 0) ? P : P/2 + 2, tr);
        if ($urandom_range(0, 14) == 0) rst_a[tr + $urandom_range(1, 70)] = 1;
      end
    end
    put(1'b1, 200);

    run_model();

    // hand-derived anchors for the model
    chk("pin_a5_valid",   t1 + lat0,     32'(ex_dv[t1 + lat0]),     32'd1);
    chk("pin_a5_data",    t1 + lat0,     32'(ex_pd[t1 + lat0]),     32'hA5);
    chk("pin_a5_busy_hi", t1 + lat0,     32'(ex_busy[t1 + lat0]),   32'd1);
    chk("pin_a5_busy_lo", t1 + lat0 + 1, 32'(ex_busy[t1 + lat0+1]), 32'd0);
    chk("pin_37_valid",   t2 + latp,     32'(ex_dv[t2 + latp]),     32'd1);
    chk("pin_37_data",    t2 + latp,     32'(ex_pd[t2 + latp]),     32'h37);
    chk("pin_par_err",    t3 + latp,     32'(ex_pe[t3 + latp]),     32'd1);
    chk("pin_par_novld",  t3 + latp,     32'(ex_dv[t3 + latp]),     32'd0);
    chk("pin_stop_err",   t4 + lat0,     32'(ex_se[t4 + lat0]),     32'd1);
    chk("pin_stop_hold",  t4 + lat0,     32'(ex_pd[t4 + lat0]),     32'h37);
    chk("pin_glitch_b1",  t5 + 1,        32'(ex_busy[t5 + 1]),      32'd1);
    chk("pin_glitch_b0",  t5 + P/2+MAJ+1, 32'(ex_busy[t5 + P/2 + MAJ + 1]), 32'd0);
    chk("pin_b2b_01",     t6 + lat0,     32'(ex_pd[t6 + lat0]),     32'h01);
    chk("pin_b2b_ff",     t7 + lat0,     32'(ex_pd[t7 + lat0]),     32'hFF);
    chk("pin_rst_data",   t8 + 31,       32'(ex_pd[t8 + 31]),       32'h00);
    chk("pin_rst_busy",   t8 + 31,       32'(ex_busy[t8 + 31]),     32'd0);
    chk("pin_3c_data",    t9 + lat0,     32'(ex_pd[t9 + lat0]),     32'h3C);

    // drive the waveform; compare happens on each falling edge
    reset = 1'b1; serial_data_in = 1'b1; parity_enable = 1'b0; parity_type = 1'b0;
    @(posedge clk); #1;
    running = 1;
    for (int n = 0; n < len; n++) begin
      cyc            = n;
      reset          = rst_a[n];
      serial_data_in = line_a[n];
      parity_enable  = pe_a[n];
      parity_type    = pt_a[n];
      @(posedge clk); #1;
    end
    running = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Receive-side counterpart of the UART transmitter. It consumes the serial line (the transmitter's serial_data_out) and oversamples it PRESCALE times per bit. It detects start, data (LSB first), optional parity and stop bits, and presents the recovered word with a one-cycle valid pulse and error flags. It sits at the RX end of the UART link, feeding the parallel consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE, 8, receiver clk cycles per serial bit; even, >= 4

Ports:
clk  input  1  receiver clock; bit period = PRESCALE cycles
reset  input  1  synchronous, active-high reset
serial_data_in  input  1  serial line, idles high; already synchronous to clk
parity_enable  input  1  1 = frame carries a parity bit
parity_type  input  1  0 = even, 1 = odd (same encoding as the transmitter)
parallel_data  output  DATA_WIDTH  last clean received word
data_valid  output  1  one-cycle pulse: parallel_data updated with a clean frame
parity_error  output  1  one-cycle pulse: parity mismatch
stop_error  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (synchronous, active-high, clk only): state IDLE, counters 0. parallel_data=0, data_valid=0, parity_error=0, stop_error=0, busy=0. Reset mid-frame discards the partial frame with no pulses.
- Oversample counter cnt runs 0..PRESCALE-1 within each bit. Sample point is cnt==PRESCALE/2. At cnt==PRESCALE-1, cnt wraps to 0 and the bit ends.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when serial_data_in==0, the current cycle is cnt=0 of the start bit. The FSM goes to START with cnt=1 next cycle, and latches parity_enable and parity_type. Changes to these inputs mid-frame are ignored.
- START: at the sample point, line==1 is a glitch: return to IDLE with no pulses. Otherwise, at bit end go to DATA with bit index 0.
- DATA: sample bit i into shift register position i (LSB first). At bit end after index DATA_WIDTH-1, go to PARITY if latched parity_enable, else STOP.
- PARITY: at the sample point compute the expected bit = XOR(data) XOR parity_type. A mismatch sets an internal flag. At bit end go to STOP.
- STOP: at the sample point, return to IDLE on the next cycle; no wait for the end of the stop bit, so back-to-back frames resync. In the cycle after the sample point:
  - Stop==1 and no parity mismatch: data_valid=1 and parallel_data loads the word.
  - Stop==0: stop_error=1.
  - Parity mismatch: parity_error=1.
  - Both errors can pulse together. On any error, data_valid stays 0 and parallel_data holds its old value.
- Latency (PRESCALE=8, DATA_WIDTH=8, start edge at cycle 0):
  - No parity: stop sampled at cycle 76; pulses at cycle 77.
  - With parity: stop sampled at cycle 84; pulses at cycle 85.
- busy: 1 from the cycle after start detection until IDLE is re-entered, including the pulse cycle. Glitch abort clears busy.
- A low line in the IDLE cycle right after STOP is treated as a new start edge.
- Pulse outputs are registered and last exactly one cycle.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the 2-of-3 majority of the samples at cnt = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1. The decision is taken at PRESCALE/2+1, so all pulses move one cycle later (77 becomes 78).
- Undefined: single sample at PRESCALE/2.
- The start-glitch check uses the same voting rule in both builds.

Decomposition:
- Package uart_rx_pkg: FSM state encoding (IDLE..STOP), PARITY_EVEN=1'b0 and PARITY_ODD=1'b1, and the derived sample-point constant.
- One sub-module, uart_rx_bit_sampler: holds cnt and the sampling/voting logic. Outputs sample_valid, sampled_bit and bit_end. The FSM, shift register and parity check stay in uart_receiver.

Test Plan:
- Reset deasserted, PRESCALE=8, no parity, frame 0xA5 -> data_valid at cycle 77, parallel_data=0xA5, no error pulses, busy low at cycle 78.
- parity_enable=1, parity_type=0, 0x37 with parity bit 1 -> data_valid at cycle 85, parallel_data=0x37. Same frame with parity bit 0 -> parity_error pulse, data_valid=0, parallel_data unchanged.
- 0x5A with stop bit driven 0 -> stop_error pulse at cycle 77, data_valid=0, parallel_data unchanged.
- Line low for 3 cycles, then high -> no pulses; busy rises, then falls after the sample point.
- Back-to-back frames 0x01, 0xFF with next start immediately after the stop bit -> two data_valid pulses with the correct values.
- reset asserted at cycle 30 of a frame -> all outputs 0 next cycle, no pulses. A following clean frame 0x3C is received correctly.
